// File: rtl/unidade_hazard_forward.sv
// Hazard detection and operand forwarding for a 5-stage pipeline: registered
// forwarding selects, load-use / multiply / taken-branch stall control and a stall counter.
module unidade_hazard_forward (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  rsIFID,
  input  logic [4:0]  rtIFID,
  input  logic [4:0]  rtIDEX,
  input  logic [4:0]  destinoIDEX,
  input  logic        memReadIDEX,
  input  logic        regWriteIDEX,
  input  logic [4:0]  destinoEXMEM,
  input  logic        regWriteEXMEM,
  input  logic        desvioTomado,
  input  logic        inicioMult,
  output logic [1:0]  forwardA,
  output logic [1:0]  forwardB,
  output logic        pararPC,
  output logic        pararIFID,
  output logic        bolhaIDEX,
  output logic        flushIFID,
  output logic [15:0] contadorBolhas
);

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    MULT   = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_ALU = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  state_t      state_q, state_d;
  logic [1:0]  mult_cnt_q, mult_cnt_d;
  logic [15:0] bolhas_q, bolhas_d;
  logic        load_use;
  logic        stall_pc, stall_ifid, bubble, flush;
  logic [4:0]  src_reg [2];

  assign src_reg[0] = rsIFID;
  assign src_reg[1] = rtIFID;

  assign load_use = memReadIDEX && (rtIDEX != 5'd0) &&
                    ((rtIDEX == rsIFID) || (rtIDEX == rtIFID));

  // Next state and raw control; a taken branch overrides everything and kills a multiply.
  always_comb begin
    state_d    = state_q;
    mult_cnt_d = mult_cnt_q;
    stall_pc   = 1'b0;
    stall_ifid = 1'b0;
    bubble     = 1'b0;
    flush      = 1'b0;
    if (desvioTomado) begin
      flush      = 1'b1;
      bubble     = 1'b1;
      state_d    = FLUSH;
      mult_cnt_d = 2'd0;
    end else begin
      case (state_q)
        MULT: begin
          stall_pc   = 1'b1;
          stall_ifid = 1'b1;
          if (mult_cnt_q == 2'd0) begin
            state_d = NORMAL;
          end else begin
            mult_cnt_d = mult_cnt_q - 2'd1;
          end
        end
        FLUSH: begin
          flush   = 1'b1;
          state_d = NORMAL;
        end
        NORMAL: begin
          if (load_use) begin
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
            bubble     = 1'b1;
          end
          if (inicioMult) begin
            state_d    = MULT;
            mult_cnt_d = 2'd3;
          end
        end
        default: begin
          state_d    = NORMAL;
          mult_cnt_d = 2'd0;
        end
      endcase
    end
  end

  // Control outputs are forced low while reset is held.
  assign pararPC   = reset & stall_pc;
  assign pararIFID = reset & stall_ifid;
  assign bolhaIDEX = reset & bubble;
  assign flushIFID = reset & flush;

  always_comb begin
    bolhas_d = bolhas_q;
    if (pararPC && (bolhas_q != 16'hFFFF)) begin
      bolhas_d = bolhas_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= NORMAL;
      mult_cnt_q <= 2'd0;
      bolhas_q   <= 16'd0;
    end else begin
      state_q    <= state_d;
      mult_cnt_q <= mult_cnt_d;
      bolhas_q   <= bolhas_d;
    end
  end

  assign contadorBolhas = bolhas_q;

  // One forwarding channel per ID source operand; computed a cycle early so the
  // select is ready when the operand reaches EX.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic       ex_hit, mem_hit;
      logic [1:0] fwd_d, fwd_q;

      assign ex_hit  = regWriteIDEX  && (destinoIDEX  != 5'd0) && (destinoIDEX  == src_reg[gi]);
      assign mem_hit = regWriteEXMEM && (destinoEXMEM != 5'd0) && (destinoEXMEM == src_reg[gi]);

      always_comb begin
        fwd_d = fwd_q;
        if (!pararIFID) begin
          if (ex_hit) begin
            fwd_d = FWD_ALU;
          end else if (mem_hit) begin
            fwd_d = FWD_WB;
          end else begin
            fwd_d = FWD_RF;
          end
        end
      end

      always_ff @(posedge clock) begin
        if (!reset) begin
          fwd_q <= FWD_RF;
        end else begin
          fwd_q <= fwd_d;
        end
      end
    end
  endgenerate

  assign forwardA = g_fwd[0].fwd_q;
  assign forwardB = g_fwd[1].fwd_q;

endmodule

// File: doc/unidade_hazard_forward.md
UNIDADE_HAZARD_FORWARD -- requirements
Module: unidade_hazard_forward

Interface
REQ-001 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clock.
REQ-003 The block SHALL have ports rsIFID and rtIFID, input, 5 bits each: source registers of the instruction in ID.
REQ-004 The block SHALL have ports rtIDEX and destinoIDEX, input, 5 bits each: rt and final destination register of the instruction in EX.
REQ-005 The block SHALL have ports memReadIDEX and regWriteIDEX, input, 1 bit each: EX instruction is a load / writes a register.
REQ-006 The block SHALL have ports destinoEXMEM, input, 5 bits, and regWriteEXMEM, input, 1 bit: MEM-stage destination and write enable.
REQ-007 The block SHALL have port desvioTomado, input, 1 bit: branch resolved taken in EX this cycle.
REQ-008 The block SHALL have port inicioMult, input, 1 bit: multi-cycle multiply entered EX this cycle.
REQ-009 The block SHALL have ports forwardA and forwardB, output, 2 bits each, registered: 00 register file, 10 ALU result, 01 write-back result.
REQ-010 The block SHALL have ports pararPC, pararIFID, bolhaIDEX, flushIFID, output, 1 bit each, combinational from state and inputs.
REQ-011 The block SHALL have port contadorBolhas, output, 16 bits, registered: count of stall cycles inserted.

Function
REQ-012 forwardA SHALL be registered each edge as 10 if regWriteIDEX=1, destinoIDEX!=0 and destinoIDEX==rsIFID; else 01 if regWriteEXMEM=1, destinoEXMEM!=0 and destinoEXMEM==rsIFID; else 00.
REQ-013 forwardB SHALL follow REQ-012 with rtIFID in place of rsIFID.
REQ-014 Codes SHALL be computed one cycle ahead: the EX instruction becomes the MEM-stage source and the MEM-stage instruction becomes the write-back source when the ID instruction reaches EX.
REQ-015 While pararIFID=1, forwardA/forwardB SHALL hold their previous values.
REQ-016 Load-use SHALL be detected when memReadIDEX=1, rtIDEX!=0 and rtIDEX equals rsIFID or rtIDEX equals rtIFID.
REQ-017 FSM states SHALL be NORMAL, MULT, FLUSH; reset state NORMAL.
REQ-018 In NORMAL, load-use detection SHALL assert pararPC=1, pararIFID=1, bolhaIDEX=1 for exactly that cycle; state stays NORMAL.
REQ-019 In NORMAL with inicioMult=1, next state SHALL be MULT, and a 2-bit counter SHALL load 3.
REQ-020 In MULT, pararPC=1 and pararIFID=1 and bolhaIDEX=0 SHALL hold every cycle; counter decrements; the cycle with counter=0 returns to NORMAL (4 stall cycles total).
REQ-021 desvioTomado=1 in any state SHALL assert flushIFID=1 and bolhaIDEX=1 that cycle, force pararPC=0, and move to FLUSH, aborting any MULT count.
REQ-022 In FLUSH, one cycle, flushIFID=1 and bolhaIDEX=0 SHALL hold, load-use detection is ignored, and the next state is NORMAL.
REQ-023 Priority SHALL be desvioTomado > MULT stall > load-use; inicioMult during MULT or FLUSH SHALL be ignored.
REQ-024 contadorBolhas SHALL increment by 1 on each cycle with pararPC=1 and saturate at 0xFFFF.

Reset
REQ-025 With reset=0 at a rising edge, the block SHALL set state NORMAL, mult counter 0, forwardA=forwardB=00, contadorBolhas=0.
REQ-026 During reset cycles, all combinational control outputs SHALL be 0 regardless of inputs.
REQ-027 Reset asserted mid-MULT or mid-FLUSH SHALL abort and return to NORMAL on that edge.

Verification
REQ-028 Scenario: regWriteIDEX=1, destinoIDEX=5, regWriteEXMEM=1, destinoEXMEM=5, rsIFID=5 -> next cycle forwardA=10 (EX priority).
REQ-029 Scenario: destinoIDEX=0 with rsIFID=0, regWriteIDEX=1 -> forwardA=00.
REQ-030 Scenario: memReadIDEX=1, rtIDEX=8, rtIFID=8 -> single cycle pararPC=pararIFID=bolhaIDEX=1 and contadorBolhas +1.
REQ-031 Scenario: inicioMult pulse -> pararPC=1 for exactly 4 cycles, then 0, and contadorBolhas +4.
REQ-032 Scenario: desvioTomado=1 in the 2nd MULT cycle -> flushIFID=1 for 2 cycles, pararPC=0, then NORMAL.
REQ-033 Scenario: counter preloaded to 0xFFFF by 65535 stalls, then 1 more stall -> contadorBolhas stays 0xFFFF; reset=0 -> 0.
